// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full-adder cell, LSB first
module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
endmodule

module serial_add_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out
);
  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NUM_BITS-1:0] a_sr;
  logic [NUM_BITS-1:0] b_sr;
  logic [NUM_BITS-1:0] sum_sr;
  logic                carry_q;
  logic                carry_out_q;
  logic [CW-1:0]       count_q;
  logic                fa_sum;
  logic                fa_carry;
  logic                last_bit;
  logic                accept;

  serial_add_fa u_fa (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  assign last_bit = (count_q == CW'(NUM_BITS - 1));
  assign accept   = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sum bits enter at the MSB so after NUM_BITS shifts the LSB lands at bit 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      count_q     <= '0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      carry_q <= carry_in;
      count_q <= '0;
    end else if (state_q == S_ADD) begin
      a_sr    <= {1'b0, a_sr[NUM_BITS-1:1]};
      b_sr    <= {1'b0, b_sr[NUM_BITS-1:1]};
      sum_sr  <= {fa_sum, sum_sr[NUM_BITS-1:1]};
      carry_q <= fa_carry;
      if (last_bit) carry_out_q <= fa_carry;
      else          count_q     <= count_q + 1'b1;
    end
  end

  assign sum       = sum_sr;
  assign carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized and directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.NUM_BITS(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase 0 = idle, 1..N = adding, N+1 = done cycle.
  int         phase = 0;
  logic [N:0] pending = '0;
  logic [N:0] result = '0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase   = 0;
      pending = '0;
      result  = '0;
    end else if (phase == 0) begin
      if (start) begin
        pending = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};
        phase   = 1;
      end
    end else if (phase <= N) begin
      phase++;
      if (phase == N + 1) result = pending;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    chk("model_busy", {63'd0, busy}, {63'd0, (phase >= 1 && phase <= N)});
    chk("model_done", {63'd0, done}, {63'd0, (phase == N + 1)});
    chk("model_carry_out", {63'd0, carry_out}, {63'd0, result[N]});
    if (phase == 0 || phase == N + 1)
      chk("model_sum", {56'd0, sum}, {56'd0, result[N-1:0]});
  end

  task automatic wait_done(input string name, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) break;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic vc, input logic [N-1:0] es, input logic ec);
    int cyc, bcyc;
    @(negedge clk);
    a = va; b = vb; carry_in = vc; start = 1'b1;
    wait_done(name, cyc, bcyc);
    chk({name, "_latency"}, cyc, N + 1);
    chk({name, "_busy_cycles"}, bcyc, N);
    chk({name, "_sum"}, {56'd0, sum}, {56'd0, es});
    chk({name, "_carry_out"}, {63'd0, carry_out}, {63'd0, ec});
  endtask

  initial begin
    int cyc, bcyc, ndone, last_t;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_sum", {56'd0, sum}, 64'd0);
    chk("reset_carry_out", {63'd0, carry_out}, 64'd0);
    n_rst = 1'b1;

    run_op("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("op_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("op_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("op_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // start and operand changes while busy must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; carry_in = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("ignore", cyc, bcyc);
    chk("ignore_sum", {56'd0, sum}, 64'h46);
    chk("ignore_carry_out", {63'd0, carry_out}, 64'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignore_single_done", ndone, 0);

    // reset in the 4th add cycle aborts the operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", {56'd0, sum}, 64'd0);
    chk("abort_carry_out", {63'd0, carry_out}, 64'd0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("op_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // start held high: one done every N+2 cycles
    @(negedge clk);
    a = 8'h80; b = 8'h80; carry_in = 1'b0; start = 1'b1;
    ndone = 0; last_t = 0;
    for (int t = 1; t <= 45; t++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_sum", {56'd0, sum}, 64'h00);
        chk("b2b_carry_out", {63'd0, carry_out}, 64'd1);
        if (ndone > 0) chk("b2b_interval", t - last_t, N + 2);
        last_t = t;
        ndone++;
      end
    end
    chk("b2b_count", ndone, 4);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      a        = N'($urandom);
      b        = N'($urandom);
      carry_in = 1'($urandom);
      if (i % 1000 == 777) begin
        #2 n_rst = 1'b0;
        @(negedge clk);
        #2 n_rst = 1'b1;
      end
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
